// File: rtl/mips_muldiv_unit.sv
// mips_muldiv_unit: iterative MIPS multiply/divide unit with architectural HI/LO registers
module mips_muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int UNROLL = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] rs_data,
  input  logic [DATA_WIDTH-1:0] rt_data,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);
  localparam int W = DATA_WIDTH;
  localparam int N = W / UNROLL;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt;
  logic [2*W-1:0] acc, acc_nxt, prod;
  logic [W-1:0] m, rs_mag, rt_mag, quo, rem;
  logic is_div, neg_res, neg_rem, dz;
  logic accept, mdop, sgn, rs_neg, rt_neg, rt_zero;

  // One iteration: shift-add for multiply ({upper,multiplier}), restoring shift-subtract for divide ({rem,quotient})
  function automatic logic [2*W-1:0] step(input logic [2*W-1:0] p, input logic [W-1:0] d, input logic dv);
    logic [W:0] s, t;
    s = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, d} : '0);
    t = p[2*W-1:W-1] - {1'b0, d};
    return dv ? (t[W] ? {p[2*W-2:0], 1'b0} : {t[W-1:0], p[W-2:0], 1'b1}) : {s, p[W-1:1]};
  endfunction

  assign accept = state == IDLE && start && !cancel;
  assign mdop = accept && !op[2];
  assign sgn = !op[0];
  assign rs_neg = sgn && rs_data[W-1];
  assign rt_neg = sgn && rt_data[W-1];
  assign rs_mag = rs_neg ? -rs_data : rs_data;
  assign rt_mag = rt_neg ? -rt_data : rt_data;
  assign rt_zero = op[1] && rt_data == '0;
  assign busy = state != IDLE;
  assign prod = neg_res ? -acc : acc;
  assign quo = neg_res ? -acc[W-1:0] : acc[W-1:0];
  assign rem = neg_rem ? -acc[2*W-1:W] : acc[2*W-1:W];

  // Next state: a zero divisor skips RUN, cancel always returns to IDLE
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (mdop ? (rt_zero ? FIX : RUN) : IDLE)
              : state == RUN && !cancel ? (cnt == CW'(1) ? FIX : RUN) : IDLE;
  end

  // UNROLL iterations retired per RUN cycle
  always_comb begin
    acc_nxt = acc;
    for (int i = 0; i < UNROLL; i++) acc_nxt = step(acc_nxt, m, is_div);
  end

  // State register
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;

  // Operand capture, iteration, sign fix-up and HI/LO writeback
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      acc <= '0;
      m <= '0;
      is_div <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dz <= 1'b0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
      hi <= '0;
      lo <= '0;
    end else begin
      done <= state == FIX && !cancel;
      div_by_zero <= state == FIX && !cancel && dz;
      if (mdop) begin
        cnt <= CW'(N);
        acc <= rt_zero ? {rs_data, {W{1'b1}}} : {{W{1'b0}}, op[1] ? rs_mag : rt_mag};
        m <= op[1] ? rt_mag : rs_mag;
        is_div <= op[1];
        neg_res <= rs_neg ^ rt_neg;
        neg_rem <= rs_neg;
        dz <= rt_zero;
      end else if (state == RUN) begin
        cnt <= cnt - CW'(1);
        acc <= acc_nxt;
      end
      if (accept && op == 3'd4) hi <= rs_data;
      if (accept && op == 3'd5) lo <= rs_data;
      if (state == FIX && !cancel) begin
        hi <= dz ? acc[2*W-1:W] : is_div ? rem : prod[2*W-1:W];
        lo <= dz ? acc[W-1:0] : is_div ? quo : prod[W-1:0];
      end
    end
  end
endmodule
